// File: rtl/ysyx_23060201_lsu.sv
// Simulated physical memory and the load/store unit that drives it.
//
// ysyx_23060201_pmem_pkg
//   Behavioural stand-in for the pmem_read/pmem_write hooks. It keeps a
//   small word array indexed by addr[9:2] and counts every call, so that
//   tools outside the LSU can see when memory traffic happened.
//
// ysyx_23060201_lsu
//   Clocked load/store unit. It accepts one request per valid/ready
//   handshake. After an optional LATENCY, it performs exactly one memory call
//   on a clock edge and returns load data or an alignment error through a
//   response handshake.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : request present
//   req_ready     : unit idle and able to accept
//   req_wen       : 1 = store, 0 = load
//   req_addr      : byte address
//   req_wdata     : store data, right-aligned
//   req_size      : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  : load zero-extend (1) / sign-extend (0)
//   rsp_valid     : response present
//   rsp_ready     : consumer takes the response
//   rsp_rdata     : load result, 0 for stores and errors
//   rsp_err       : misaligned access or illegal size

package ysyx_23060201_pmem_pkg;

  logic [31:0] mem [256];
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  wr_mask;

  function automatic logic [31:0] pmem_read(input logic [31:0] raddr);
    rd_cnt = rd_cnt + 1;
    return mem[raddr[9:2]];
  endfunction

  function automatic void pmem_write(input logic [31:0] waddr, input logic [31:0] wdata,
                                     input logic [7:0] wmask);
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) mem[waddr[9:2]][8*i +: 8] = wdata[8*i +: 8];
    end
    wr_addr = waddr;
    wr_data = wdata;
    wr_mask = wmask;
    wr_cnt  = wr_cnt + 1;
  endfunction

endpackage

module ysyx_23060201_lsu
  import ysyx_23060201_pmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("ysyx_23060201_lsu: DATA_WIDTH must be 32");
  end
  if (LATENCY > 15) begin : g_bad_latency
    $error("ysyx_23060201_lsu: LATENCY must be in 0..15");
  end
  if ((64'd1 << CNT_WIDTH) <= 64'(LATENCY)) begin : g_bad_cnt_width
    $error("ysyx_23060201_lsu: CNT_WIDTH too small for LATENCY");
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [1:0]            off_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic        accept;
  logic        acc_err;
  logic        access;
  logic [31:0] addr32;
  logic [31:0] addr_word;
  logic [7:0]  store_mask;

  // Memory calls see the low 32 address bits, zero-extended for narrow buses.
  if (ADDR_WIDTH >= 32) begin : g_addr_wide
    assign addr32 = addr_q[31:0];
  end else begin : g_addr_narrow
    assign addr32 = {{(32 - ADDR_WIDTH){1'b0}}, addr_q};
  end

  assign addr_word = addr32 & 32'hFFFF_FFFC;

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;
  assign access    = (state_q == StWait) && (cnt_q == '0);

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    acc_err = 1'b0;
    case (req_size)
      2'b01:   acc_err = req_addr[0];
      2'b10:   acc_err = |req_addr[1:0];
      2'b11:   acc_err = 1'b1;
      default: acc_err = 1'b0;
    endcase
  end

  always_comb begin
    store_mask = 8'h0F;
    case (size_q)
      2'b00:   store_mask = 8'h01 << off_q;
      2'b01:   store_mask = 8'h03 << off_q;
      default: store_mask = 8'h0F;
    endcase
  end

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (size)
      2'b00:   load_ext = uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      2'b01:   load_ext = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Errors skip the latency and the memory call entirely.
          if (acc_err) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CNT_WIDTH'(LATENCY);
          end
        end
      end
      StWait: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        off_q   <= req_addr[1:0];
        rdata_q <= '0;
        err_q   <= acc_err;
      end
      // The memory call lives here so it only ever happens on a clock edge
      // outside reset.
      if (access) begin
        if (wen_q) begin
          pmem_write(addr_word, wdata_q << {off_q, 3'b000}, store_mask);
        end else begin
          rdata_q <= load_ext(pmem_read(addr_word), off_q, size_q, uns_q);
        end
      end
      if ((state_q == StResp) && rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
module tb_ysyx_23060201_lsu;

  localparam int unsigned Lat1 = 1;
  localparam int unsigned Lat3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Unit under test with LATENCY=1.
  logic        rst1 = 1'b1;
  logic        req_valid1 = 1'b0, req_ready1, req_wen1 = 1'b0, req_unsigned1 = 1'b0;
  logic [31:0] req_addr1 = '0, req_wdata1 = '0;
  logic [1:0]  req_size1 = 2'b00;
  logic        rsp_valid1, rsp_ready1 = 1'b1, rsp_err1;
  logic [31:0] rsp_rdata1;

  // Unit under test with LATENCY=3, used for reset abort.
  logic        rst3 = 1'b1;
  logic        req_valid3 = 1'b0, req_ready3, req_wen3 = 1'b0, req_unsigned3 = 1'b0;
  logic [31:0] req_addr3 = '0, req_wdata3 = '0;
  logic [1:0]  req_size3 = 2'b00;
  logic        rsp_valid3, rsp_ready3 = 1'b1, rsp_err3;
  logic [31:0] rsp_rdata3;

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(Lat1), .CNT_WIDTH(4)) u_dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_wen(req_wen1), .req_addr(req_addr1), .req_wdata(req_wdata1), .req_size(req_size1),
    .req_unsigned(req_unsigned1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(Lat3), .CNT_WIDTH(4)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_wen(req_wen3), .req_addr(req_addr3), .req_wdata(req_wdata3), .req_size(req_size3),
    .req_unsigned(req_unsigned3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  mask;
  } wr_t;

  rsp_t eq[$];
  wr_t  wq[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request to the LATENCY=1 unit with hand-computed expectations.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic [31:0] exp_waddr,
                       input logic [31:0] exp_wdata, input logic [7:0] exp_wmask);
    rsp_t e;
    wr_t  w;
    int   n;
    @(negedge clk);
    req_valid1    = 1'b1;
    req_wen1      = wen;
    req_addr1     = addr;
    req_wdata1    = wdata;
    req_size1     = size;
    req_unsigned1 = uns;
    n = 0;
    while (!req_ready1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready1) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
      req_valid1 = 1'b0;
      return;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_err ? 0 : int'(Lat1) + 1;
    eq.push_back(e);
    if (wen && !exp_err) begin
      w.addr = exp_waddr;
      w.data = exp_wdata;
      w.mask = exp_wmask;
      wq.push_back(w);
    end
    @(posedge clk);
    #1;
    // Scramble the inputs: a latched request must not see later changes.
    req_valid1    = 1'b0;
    req_wen1      = ~wen;
    req_addr1     = 32'hFFFF_FFFF;
    req_wdata1    = 32'hFFFF_FFFF;
    req_size1     = 2'b11;
    req_unsigned1 = ~uns;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((eq.size() != 0 || wq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (eq.size() != 0 || wq.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d responses and %0d writes outstanding, expected 0",
               eq.size(), wq.size());
    end
  endtask

  // Monitor: compares every presented response and every memory write
  // against the queues filled by the stimulus.
  initial begin
    int          acc_cyc;
    bit          prev_valid;
    int unsigned wr_seen;
    rsp_t        e;
    wr_t         w;
    acc_cyc    = 0;
    prev_valid = 1'b0;
    wr_seen    = 0;
    forever begin
      @(negedge clk);
      #1;
      if (ysyx_23060201_pmem_pkg::wr_cnt != wr_seen) begin
        wr_seen++;
        if (wq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%08h, expected no write",
                   ysyx_23060201_pmem_pkg::wr_addr);
        end else begin
          w = wq.pop_front();
          chk("write_addr", ysyx_23060201_pmem_pkg::wr_addr, w.addr);
          chk("write_data", ysyx_23060201_pmem_pkg::wr_data, w.data);
          chk("write_mask", {24'h0, ysyx_23060201_pmem_pkg::wr_mask}, {24'h0, w.mask});
        end
      end
      if (rst1) begin
        prev_valid = 1'b0;
      end else begin
        if (req_valid1 && req_ready1) acc_cyc = cyc + 1;
        if (rsp_valid1) begin
          if (eq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rsp: got rdata 0x%08h, expected no response", rsp_rdata1);
          end else begin
            e = eq[0];
            if (!prev_valid) chk("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
            chk("rsp_rdata", rsp_rdata1, e.rdata);
            chk("rsp_err", {31'h0, rsp_err1}, {31'h0, e.err});
            if (rsp_ready1) void'(eq.pop_front());
          end
        end
        prev_valid = rsp_valid1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rd0, wr0;
    int n;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready1}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid1}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata1, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err1}, 32'h0);
    chk("rst3_req_ready", {31'h0, req_ready3}, 32'h0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'h0, req_ready1}, 32'h1);

    // Store word.
    issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0,
          32'h8000_0010, 32'hDEAD_BEEF, 8'h0F);
    // Loads of a known word with every extension mode.
    issue(1'b1, 32'h8000_0020, 32'h80F1_7F02, 2'b10, 1'b0, 32'h0, 1'b0,
          32'h8000_0020, 32'h80F1_7F02, 8'h0F);
    issue(1'b0, 32'h8000_0023, 32'h0, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0, '0, '0, '0);
    issue(1'b0, 32'h8000_0023, 32'h0, 2'b00, 1'b1, 32'h0000_0080, 1'b0, '0, '0, '0);
    issue(1'b0, 32'h8000_0022, 32'h0, 2'b01, 1'b0, 32'hFFFF_80F1, 1'b0, '0, '0, '0);
    issue(1'b0, 32'h8000_0020, 32'h0, 2'b01, 1'b1, 32'h0000_7F02, 1'b0, '0, '0, '0);
    issue(1'b0, 32'h8000_0021, 32'h0, 2'b00, 1'b0, 32'h0000_007F, 1'b0, '0, '0, '0);
    issue(1'b0, 32'h8000_0020, 32'h0, 2'b10, 1'b0, 32'h80F1_7F02, 1'b0, '0, '0, '0);
    // Sub-word stores and read-back of the affected lanes.
    issue(1'b1, 32'h8000_0005, 32'h0000_00AB, 2'b00, 1'b0, 32'h0, 1'b0,
          32'h8000_0004, 32'h0000_AB00, 8'h02);
    issue(1'b1, 32'h8000_0006, 32'h0000_1234, 2'b01, 1'b0, 32'h0, 1'b0,
          32'h8000_0004, 32'h1234_0000, 8'h0C);
    issue(1'b0, 32'h8000_0005, 32'h0, 2'b00, 1'b1, 32'h0000_00AB, 1'b0, '0, '0, '0);
    issue(1'b0, 32'h8000_0006, 32'h0, 2'b01, 1'b0, 32'h0000_1234, 1'b0, '0, '0, '0);
    drain();

    // Alignment and illegal-size errors make no memory call.
    rd0 = ysyx_23060201_pmem_pkg::rd_cnt;
    wr0 = ysyx_23060201_pmem_pkg::wr_cnt;
    issue(1'b0, 32'h8000_0002, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, '0, '0, '0);
    issue(1'b0, 32'h8000_0000, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, '0, '0, '0);
    issue(1'b0, 32'h8000_0001, 32'h0, 2'b01, 1'b1, 32'h0, 1'b1, '0, '0, '0);
    issue(1'b1, 32'h8000_0003, 32'h5, 2'b01, 1'b0, 32'h0, 1'b1, '0, '0, '0);
    drain();
    chk("err_no_read", rd0, ysyx_23060201_pmem_pkg::rd_cnt);
    chk("err_no_write", wr0, ysyx_23060201_pmem_pkg::wr_cnt);

    // Response back-pressure: data held, no new accept.
    @(negedge clk);
    rsp_ready1 = 1'b0;
    issue(1'b0, 32'h8000_0020, 32'h0, 2'b10, 1'b0, 32'h80F1_7F02, 1'b0, '0, '0, '0);
    n = 0;
    while (!rsp_valid1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_rsp_valid", {31'h0, rsp_valid1}, 32'h1);
      chk("hold_req_ready", {31'h0, req_ready1}, 32'h0);
      req_valid1 = 1'b1;
      req_wen1   = 1'b1;
      req_addr1  = 32'h8000_0030;
      req_wdata1 = 32'h0000_0055;
      req_size1  = 2'b10;
    end
    @(negedge clk);
    req_valid1 = 1'b0;
    rsp_ready1 = 1'b1;
    @(negedge clk);
    #1;
    chk("after_hs_req_ready", {31'h0, req_ready1}, 32'h1);
    chk("after_hs_rsp_valid", {31'h0, rsp_valid1}, 32'h0);
    chk("after_hs_rsp_rdata", rsp_rdata1, 32'h0);
    drain();

    // Reset one cycle after accepting a store (LATENCY=3).
    wr0 = ysyx_23060201_pmem_pkg::wr_cnt;
    @(negedge clk);
    chk("l3_req_ready", {31'h0, req_ready3}, 32'h1);
    req_valid3 = 1'b1;
    req_wen3   = 1'b1;
    req_addr3  = 32'h8000_0040;
    req_wdata3 = 32'h1111_1111;
    req_size3  = 2'b10;
    @(negedge clk);
    req_valid3 = 1'b0;
    rst3       = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("l3_rst_req_ready", {31'h0, req_ready3}, 32'h0);
    rst3 = 1'b0;
    #1;
    chk("l3_post_rst_req_ready", {31'h0, req_ready3}, 32'h1);
    chk("l3_post_rst_rsp_valid", {31'h0, rsp_valid3}, 32'h0);
    repeat (8) @(negedge clk);
    #1;
    chk("l3_rst_no_write", ysyx_23060201_pmem_pkg::wr_cnt, wr0);
    chk("l3_rst_rsp_valid", {31'h0, rsp_valid3}, 32'h0);

    // Reset on the very edge where the counter has reached zero.
    @(negedge clk);
    req_valid3 = 1'b1;
    req_addr3  = 32'h8000_0044;
    req_wdata3 = 32'h2222_2222;
    @(negedge clk);
    req_valid3 = 1'b0;
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    chk("l3_cnt0_req_ready", {31'h0, req_ready3}, 32'h1);
    chk("l3_cnt0_rsp_valid", {31'h0, rsp_valid3}, 32'h0);
    repeat (8) @(negedge clk);
    #1;
    chk("l3_cnt0_no_write", ysyx_23060201_pmem_pkg::wr_cnt, wr0);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
